// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline hazard controller. Resolves memory/MDU waits,
//                redirects, load-use and fetch waits into stall/flush controls.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             imem_req,
  input  logic             imem_ack,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t           r_state;
  logic             r_redirect_pending;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_dwait;
  logic w_mwait;
  logic w_loaduse;
  logic w_iwait;
  logic w_redirect;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_dwait    = dmem_req & ~dmem_ack;
  assign w_mwait    = ((r_state == ST_MWAIT) & ~mdu_done) |
                      ((r_state == ST_RUN) & mdu_start);
  assign w_rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
  assign w_rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
  assign w_loaduse  = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
                      (w_rs1_hit | w_rs2_hit);
  assign w_iwait    = imem_req & ~imem_ack;
  assign w_redirect = ex_redirect | r_redirect_pending;

  // Only the highest-priority active hazard drives the controls.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (reset) begin
      if (w_dwait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (w_mwait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (w_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (w_loaduse) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (w_iwait) begin
        pc_stall     = 1'b1;
        if_id_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= ST_RUN;
      r_redirect_pending <= 1'b0;
      r_stall_cycles     <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_dwait)        r_state <= ST_DWAIT;
          else if (mdu_start) r_state <= ST_MWAIT;
        end
        ST_DWAIT: if (dmem_ack) r_state <= ST_RUN;
        ST_MWAIT: if (mdu_done) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase

      // A redirect hidden behind a wait is held until the wait clears.
      if (w_dwait | w_mwait)
        r_redirect_pending <= r_redirect_pending | ex_redirect;
      else
        r_redirect_pending <= 1'b0;

      if (if_id_stall && (r_stall_cycles != c_cnt_max))
        r_stall_cycles <= r_stall_cycles + c_cnt_one;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl against a
//                behavioural hazard model, directed cases plus random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             id_valid, id_use_rs1, id_use_rs2;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             ex_valid, ex_is_load, ex_redirect;
  logic             imem_req, imem_ack, dmem_req, dmem_ack, mdu_start, mdu_done;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, ex_mem_flush, mem_wb_flush;
  logic [31:0] stall_cycles;
  logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush;
  logic        s_ex_mem_stall, s_ex_mem_flush, s_mem_wb_flush;
  logic [3:0]  s_stall_cycles;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .stall_cycles(stall_cycles)
  );

  // Narrow-counter copy to observe saturation quickly.
  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
    .ex_mem_stall(s_ex_mem_stall), .ex_mem_flush(s_ex_mem_flush),
    .mem_wb_flush(s_mem_wb_flush), .stall_cycles(s_stall_cycles)
  );

  logic [7:0] dvec, svec;
  assign dvec = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                 id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush};
  assign svec = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall,
                 s_id_ex_flush, s_ex_mem_stall, s_ex_mem_flush, s_mem_wb_flush};

  int n_tests = 0;
  int n_fail  = 0;

  // Model: MDU busy, memory-wait phase, held redirect, stall count.
  bit     m_busy, m_dphase, m_pend;
  longint m_cnt;

  function automatic bit f_dw();
    return dmem_req && !dmem_ack;
  endfunction

  function automatic bit f_mw();
    if (m_busy) return !mdu_done;
    return !m_dphase && mdu_start;
  endfunction

  // Vector order: pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f
  function automatic logic [7:0] exp_vec();
    bit lu;
    lu = ex_valid && ex_is_load && (ex_rd != 0) && id_valid &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (f_dw())                   return 8'b1101_0101;
    if (f_mw())                   return 8'b1101_0010;
    if (ex_redirect || m_pend)    return 8'b0010_1000;
    if (lu)                       return 8'b1100_1000;
    if (imem_req && !imem_ack)    return 8'b1010_0000;
    return 8'b0000_0000;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [7:0] v;
    bit dw, mw;
    if (!reset) begin
      m_busy = 0; m_dphase = 0; m_pend = 0; m_cnt = 0;
    end else begin
      v  = exp_vec();
      dw = f_dw();
      mw = f_mw();
      if (v[6]) m_cnt++;
      m_pend = (dw || mw) ? (m_pend || ex_redirect) : 1'b0;
      if (m_busy)        m_busy   = !mdu_done;
      else if (m_dphase) m_dphase = !dmem_ack;
      else if (dw)       m_dphase = 1;
      else if (mdu_start) m_busy  = 1;
    end
  endtask

  task automatic check_all();
    if (!reset) begin
      chk("reset_vec", dvec, 0);
      chk("reset_cnt", stall_cycles, 0);
      chk("reset_cnt4", s_stall_cycles, 0);
    end else begin
      chk("ctrl_vec", dvec, exp_vec());
      chk("ctrl_vec4", svec, exp_vec());
      chk("stall_cnt", stall_cycles, m_cnt);
      chk("stall_cnt4", s_stall_cycles, (m_cnt > 15) ? 15 : m_cnt);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
    imem_req = 0; imem_ack = 0; dmem_req = 0; dmem_ack = 0;
    mdu_start = 0; mdu_done = 0;
  endtask

  task automatic loaduse(input logic [REG_W-1:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    id_valid = 1; id_use_rs1 = 1; id_rs1 = rd;
  endtask

  task automatic settle();
    #3;
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m_busy = 0; m_dphase = 0; m_pend = 0; m_cnt = 0;
    #2;
    reset = 1'b0;
    dmem_req = 1; mdu_start = 1; imem_req = 1; ex_redirect = 1;
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;
    reset = 1'b1;
    idle();

    // Load-use on x5: one stall cycle, counter 0 -> 1
    loaduse(5);
    settle();
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_if_id_stall", if_id_stall, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_cnt_before", stall_cycles, 0);
    adv(); idle();
    settle();
    chk("lu_cnt_after", stall_cycles, 1);
    adv();

    // Load to x0 is never a hazard
    loaduse(0);
    settle();
    chk("lu_x0_vec", dvec, 0);
    adv(); idle();

    // Fetch wait loses to load-use
    loaduse(7); imem_req = 1;
    settle();
    chk("lu_iw_id_ex_flush", id_ex_flush, 1);
    chk("lu_iw_if_id_flush", if_id_flush, 0);
    adv(); idle();

    // MDU op: start at cycle 0, done at cycle 4
    for (int k = 0; k < 5; k++) begin
      mdu_start = (k == 0);
      mdu_done  = (k == 4);
      settle();
      chk("mdu_if_id_stall", if_id_stall, (k < 4));
      chk("mdu_id_ex_stall", id_ex_stall, (k < 4));
      chk("mdu_ex_mem_flush", ex_mem_flush, (k < 4));
      adv();
    end
    idle();
    settle();
    chk("mdu_back_to_run", dvec, 0);
    chk("mdu_cnt", stall_cycles, 6);
    adv();

    // Data wait with a redirect hidden behind it
    for (int k = 0; k < 4; k++) begin
      dmem_req    = (k < 3);
      ex_redirect = (k == 1);
      dmem_ack    = (k == 2);
      settle();
      if (k < 2) begin
        chk("dw_pc_stall", pc_stall, 1);
        chk("dw_ex_mem_stall", ex_mem_stall, 1);
        chk("dw_mem_wb_flush", mem_wb_flush, 1);
      end else if (k == 2) begin
        chk("dw_pend_if_id_flush", if_id_flush, 1);
        chk("dw_pend_id_ex_flush", id_ex_flush, 1);
        chk("dw_pend_no_stall", if_id_stall, 0);
      end else begin
        chk("dw_pend_cleared", dvec, 0);
      end
      adv();
    end

    // Long MDU wait saturates the narrow counter, then reset mid-wait
    for (int k = 0; k < 13; k++) begin
      mdu_start = (k == 0);
      settle();
      adv();
    end
    settle();
    chk("sat_cnt4", s_stall_cycles, 15);
    chk("sat_cnt32", stall_cycles, 21);
    reset = 1'b0;
    mdu_start = 1; dmem_req = 1; ex_redirect = 1;
    #1;
    chk("rst_mid_vec", dvec, 0);
    chk("rst_mid_cnt", stall_cycles, 0);
    chk("rst_mid_cnt4", s_stall_cycles, 0);
    adv();
    reset = 1'b1;
    idle();
    settle();
    chk("rst_release_run", dvec, 0);
    adv();

    // Random traffic with small register space to make hazards common
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 149) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_use_rs1  = $urandom_range(0, 1);
      id_use_rs2  = $urandom_range(0, 1);
      id_rs1      = REG_W'($urandom_range(0, 3));
      id_rs2      = REG_W'($urandom_range(0, 3));
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_is_load  = $urandom_range(0, 1);
      ex_rd       = REG_W'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 7) == 0);
      imem_req    = ($urandom_range(0, 2) == 0);
      imem_ack    = $urandom_range(0, 1);
      dmem_req    = ($urandom_range(0, 3) == 0);
      dmem_ack    = $urandom_range(0, 1);
      mdu_start   = ($urandom_range(0, 7) == 0);
      mdu_done    = ($urandom_range(0, 3) == 0);
      if (!reset) m_pend = 0;
      settle();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: REG_W, default 5, register-index width.
REQ-002 Parameter: CNT_W, default 32, stall-cycle counter width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 id_valid, id_use_rs1, id_use_rs2  input  1 each  ID-stage instruction valid and source usage.
REQ-006 id_rs1, id_rs2  input  REG_W each  ID-stage source indices.
REQ-007 ex_valid, ex_is_load  input  1 each  EX-stage instruction valid, is load.
REQ-008 ex_rd  input  REG_W  EX-stage destination index.
REQ-009 ex_redirect  input  1  EX-stage taken branch or jump; one-cycle pulse.
REQ-010 imem_req, imem_ack  input  1 each  fetch request outstanding, fetch data returned.
REQ-011 dmem_req, dmem_ack  input  1 each  data access outstanding, data access done.
REQ-012 mdu_start, mdu_done  input  1 each  multi-cycle mul/div launch pulse, completion pulse.
REQ-013 pc_stall  output  1  hold PC.
REQ-014 if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush  output  1 each  pipeline-register controls.
REQ-015 stall_cycles  output  CNT_W  count of cycles with if_id_stall=1.

Function
REQ-016 States SHALL be RUN, DWAIT, MWAIT, registered on clk; outputs combinational from state and inputs.
REQ-017 dwait = dmem_req & !dmem_ack; mwait = (state==MWAIT & !mdu_done) | (state==RUN & mdu_start); loaduse = ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); iwait = imem_req & !imem_ack.
REQ-018 Priority SHALL be dwait > mwait > redirect > loaduse > iwait; only the highest active condition drives outputs; unlisted outputs are 0.
REQ-019 dwait: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1.
REQ-020 mwait (no dwait): pc_stall, if_id_stall, id_ex_stall = 1; ex_mem_flush = 1.
REQ-021 Effective redirect = ex_redirect | redirect_pending; when it wins, if_id_flush = 1 and id_ex_flush = 1; no stalls.
REQ-022 loaduse: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1; lasts exactly the cycles the condition holds.
REQ-023 iwait: pc_stall = 1, if_id_flush = 1.
REQ-024 ex_redirect arriving while dwait or mwait is active SHALL set redirect_pending; pending is applied in the first cycle neither is active, then cleared on that edge.
REQ-025 Transitions: RUN->DWAIT on dwait; DWAIT->RUN on dmem_ack; RUN->MWAIT on mdu_start with no dwait; MWAIT->RUN on mdu_done; in MWAIT with dwait, state SHALL stay MWAIT; mdu_start while in MWAIT is ignored.
REQ-026 mdu_done cycle: mwait=0, pipeline advances, state returns to RUN.
REQ-027 stall_cycles SHALL increment by 1 each cycle if_id_stall=1 and saturate at all-ones (no wrap).
REQ-028 A stall and a flush on the same register SHALL never be asserted together.

Reset
REQ-029 While reset=0, state=RUN, redirect_pending=0, stall_cycles=0, independent of clk.
REQ-030 Outputs SHALL be 0 while reset=0, regardless of inputs.
REQ-031 Reset asserted mid-DWAIT or mid-MWAIT SHALL return to RUN and discard pending redirect; first cycle after release behaves as RUN.

Verification
REQ-032 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1, both valid, one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle; stall_cycles 0->1.
REQ-033 Load-use with ex_rd=0 -> all outputs 0.
REQ-034 mdu_start at cycle 0, mdu_done at cycle 4 -> if_id_stall=id_ex_stall=ex_mem_flush=1 cycles 0-3, 0 at cycle 4; state RUN at cycle 5; stall_cycles=4.
REQ-035 dmem_req held 3 cycles, ex_redirect pulse in cycle 1, dmem_ack in cycle 2 -> stalls in cycles 0-1; cycle 2 has if_id_flush=id_ex_flush=1; pending cleared after cycle 2.
REQ-036 iwait and loaduse simultaneous -> loaduse outputs only (id_ex_flush=1, if_id_flush=0).
REQ-037 stall_cycles preloaded near saturation (CNT_W=4, at 15) plus 3 stall cycles -> stays 15; reset=0 mid-MWAIT -> state RUN, outputs 0 immediately.
